// File: rtl/apb_slave_mem.sv
// Byte-wide APB slave backed by a small register memory; the wait-state count is a parameter.
// state  | meaning
// IDLE   | no transfer, waiting for a setup phase
// SETUP  | address/data latched, waiting for penable
// ACCESS | counting wait states; pready when the count reaches WAIT_STATES
// DONE   | one-cycle tail that can accept a back-to-back setup
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       pselx,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  mem_q [DEPTH];
    logic        mem_we;
    logic        err;
    logic [AW-1:0] idx;

    assign err     = ({1'b0, addr_q} >= 9'(DEPTH));
    assign idx     = addr_q[AW-1:0];
    assign pready  = (state_q == ACCESS) && (wait_q == 4'(WAIT_STATES));
    assign pslverr = pready && err;
    assign prdata  = (pready && !write_q && !err) ? mem_q[idx] : 8'h00;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        wait_d  = wait_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // pselx with penable already high is a protocol violation and is ignored
                if (pselx && !penable) begin
                    state_d = SETUP;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    wait_d  = '0;
                end
            end
            SETUP: begin
                if (!pselx) begin
                    state_d = IDLE;
                end else if (penable) begin
                    state_d = ACCESS;
                end else begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    wait_d  = '0;
                end
            end
            ACCESS: begin
                if (pready) begin
                    state_d = DONE;
                    mem_we  = write_q && !err;
                end else if (!pselx || !penable) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE: begin
                if (pselx && !penable) begin
                    state_d = SETUP;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    wait_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit on the completing edge so a read in the very next transfer sees the new data
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule
